// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding, widths and the iteration count.
package mdu_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned RID_W = 3;
  localparam int unsigned ITER  = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    MULLO = 2'b00,
    MULHI = 2'b01,
    DIVQ  = 2'b10,
    DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_addsub.sv
// W-bit add/subtract with carry-out; in subtract mode carry-out = 1 means no borrow.
module mdu_addsub #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff           = sub_i ? ~b_i : b_i;
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, sub_i};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, 16 RUN cycles.
// Define MUL_DIV_UNIT_DIV_EN to build the divider; otherwise DIVQ/DIVR return 0 after 1 cycle.
module mul_div_unit #(
  parameter int unsigned DW    = mdu_pkg::DW,
  parameter int unsigned RID_W = mdu_pkg::RID_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [DW-1:0]    Op_A,
  input  logic [DW-1:0]    Op_B,
  input  logic [RID_W-1:0] Dst_ID,
  output logic             Busy,
  output logic             Done,
  output logic [DW-1:0]    Result,
  output logic [RID_W-1:0] Res_W_ID,
  output logic             Div_By_Zero
);

  import mdu_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [DW-1:0]      opnd_q, opnd_d;
  logic [DW-1:0]      hi_q, hi_d;
  logic [DW-1:0]      lo_q, lo_d;
  logic [RID_W-1:0]   dst_q, dst_d;
  logic [DW-1:0]      res_q, res_d;
  logic [RID_W-1:0]   id_q, id_d;
  logic               dbz_q, dbz_d;

  logic               run_last;
  logic [DW:0]        add_a, add_b, add_sum;
  logic               add_sub, add_cout;

  mdu_addsub #(.W(DW + 1)) u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .sub_i (add_sub),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

`ifdef MUL_DIV_UNIT_DIV_EN
  logic div_zero;
  assign div_zero = is_div(op_q) && (opnd_q == '0);
`else
  logic unused_cout;
  assign unused_cout = add_cout;
`endif

  // Divide-by-zero (or a removed divider) finishes after a single RUN cycle.
  always_comb begin
    run_last = (cnt_q == CNT_W'(ITER - 1));
`ifdef MUL_DIV_UNIT_DIV_EN
    if (div_zero) run_last = 1'b1;
`else
    if (is_div(op_q)) run_last = 1'b1;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    state_d = Start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_q == RUN);
    Done = (state_q == DONE);
  end

  // Multiply shifts the product right through {hi,lo}; divide shifts the
  // dividend left out of lo into the remainder in hi, quotient bits enter lo.
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = {1'b0, opnd_q};
    add_sub = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
    if (is_div(op_q)) begin
      add_a   = {hi_q, lo_q[DW-1]};
      add_sub = 1'b1;
    end
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dst_d  = dst_q;
    res_d  = res_q;
    id_d   = id_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          op_d   = op_e'(Op);
          opnd_d = Op[1] ? Op_B : Op_A;
          lo_d   = Op[1] ? Op_A : Op_B;
          hi_d   = '0;
          dst_d  = Dst_ID;
          cnt_d  = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!is_div(op_q)) begin
          if (lo_q[0]) {hi_d, lo_d} = {add_sum, lo_q[DW-1:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[DW-1:1]};
        end
`ifdef MUL_DIV_UNIT_DIV_EN
        else if (!div_zero) begin
          hi_d = add_cout ? add_sum[DW-1:0] : add_a[DW-1:0];
          lo_d = {lo_q[DW-2:0], add_cout};
        end
`endif
        if (run_last) begin
          id_d  = dst_q;
          dbz_d = 1'b0;
          case (op_q)
            MULLO:   res_d = lo_d;
            MULHI:   res_d = hi_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            DIVQ:    res_d = div_zero ? '1 : lo_d;
            DIVR:    res_d = div_zero ? lo_q : hi_d;
`endif
            default: res_d = '0;
          endcase
`ifdef MUL_DIV_UNIT_DIV_EN
          dbz_d = div_zero;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      op_q   <= MULLO;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dst_q  <= '0;
      res_q  <= '0;
      id_q   <= '0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dst_q  <= dst_d;
      res_q  <= res_d;
      id_q   <= id_d;
      dbz_q  <= dbz_d;
    end
  end

  assign Result      = res_q;
  assign Res_W_ID    = id_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameters SHALL be: DW, 16, operand/result width; RID_W, 3, register ID width (8 registers).
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request strobe, sampled on posedge CLK.
REQ-005 Op  input  2  operation: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR.
REQ-006 Op_A  input  DW  first operand, driven from register-file Reg_RData1.
REQ-007 Op_B  input  DW  second operand, driven from register-file Reg_RData2.
REQ-008 Dst_ID  input  RID_W  destination register ID for the write-back.
REQ-009 Busy  output  1  high while an operation is iterating.
REQ-010 Done  output  1  one-cycle pulse; drives register-file Reg_WE.
REQ-011 Result  output  DW  result; drives Reg_WData.
REQ-012 Res_W_ID  output  RID_W  latched Dst_ID; drives REG_W_ID.
REQ-013 Div_By_Zero  output  1  status flag for the last completed divide.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with Busy = (state == RUN).
REQ-015 Start in IDLE or DONE SHALL latch Op, Op_A, Op_B and Dst_ID, clear the iteration counter, and enter RUN on the same edge.
REQ-016 Start in RUN SHALL be ignored, with no effect on latched operands or the counter.
REQ-017 Operands SHALL be treated as unsigned.
REQ-018 MULLO/MULHI SHALL use a radix-2 shift-add over exactly 16 RUN cycles into a 32-bit product; MULLO returns product[15:0] and MULHI returns product[31:16].
REQ-019 DIVQ/DIVR SHALL use a restoring divide over exactly 16 RUN cycles; DIVQ returns the quotient and DIVR returns the remainder.
REQ-020 Divide with latched Op_B == 0 SHALL skip iteration: RUN lasts 1 cycle, then DONE with DIVQ = 0xFFFF, DIVR = Op_A, Div_By_Zero = 1.
REQ-021 Timing: Start sampled at edge E0 gives Busy high for cycles E0..E16; edge E16 enters DONE; Done is high for exactly the cycle E16..E17; total latency is 17 cycles Start-to-Done. Divide-by-zero: Done occurs after E1.
REQ-022 Result, Res_W_ID and Div_By_Zero SHALL update only on the RUN->DONE edge and hold until the next completion or reset.
REQ-023 Div_By_Zero SHALL be 0 for any multiply completion.
REQ-024 DONE SHALL go to IDLE on the next edge without Start, or to RUN with Start (back-to-back operation, no bubble).
REQ-025 Done SHALL never be high while Busy is high.

Reset
REQ-026 RST SHALL asynchronously force: state IDLE, Busy 0, Done 0, Result 0x0000, Res_W_ID 0, Div_By_Zero 0, counter 0, internal accumulators 0.
REQ-027 RST asserted mid-RUN SHALL abort the operation with no Done pulse; the first Start after RST deasserts behaves exactly as REQ-015.

Configuration
REQ-028 Macro MUL_DIV_UNIT_DIV_EN defined SHALL build the divider as specified.
REQ-029 Macro MUL_DIV_UNIT_DIV_EN undefined SHALL remove the divider datapath; DIVQ/DIVR then take 1 RUN cycle, then DONE with Result 0x0000 and Div_By_Zero tied to 0. Multiply behaviour is unchanged.

Structure
REQ-030 Package mdu_pkg SHALL hold: the Op encoding constants (MULLO, MULHI, DIVQ, DIVR), the FSM state encoding, DW, RID_W, and ITER = 16.
REQ-031 One sub-module, mdu_addsub (DW+1-bit add/subtract with carry-out), SHALL be shared by the multiply add and the divide trial subtract.
REQ-032 The counter SHALL be 5 bits; RUN exits when the count reaches ITER-1.

Verification
REQ-033 MULLO, A=300, B=200 -> Done at cycle 17, Result=0xEA60, Res_W_ID=Dst_ID, Div_By_Zero=0.
REQ-034 MULHI, A=0xFFFF, B=0xFFFF -> Result=0xFFFE; MULLO on the same operands -> 0x0001.
REQ-035 DIVQ then DIVR, A=1000, B=7, issued back-to-back with Start in DONE -> 142 then 6, no idle cycle between RUN periods.
REQ-036 DIVQ, A=0x1234, B=0 -> Done 2 cycles after Start, Result=0xFFFF, Div_By_Zero=1; DIVR on the same operands -> 0x1234.
REQ-037 Start a MULLO, then pulse Start with new operands at RUN cycle 5 -> second request ignored, original result delivered at cycle 17.
REQ-038 Assert RST at RUN cycle 8 -> all outputs 0 immediately, no Done pulse; new Start after release -> correct result 17 cycles later.
